// File: rtl/opmode_sequencer.sv
// opmode_sequencer: programmable micro-sequencer driving the DSP48E1 X/Y/Z
// operand-select fields (OPMODE[1:0], [3:2], [6:4]) under a valid/ready handshake.
// Optional build macro: OPSEQ_LOOP_EN -- after the last entry, wrap back to entry 0
// and repeat until abort instead of finishing with a done pulse.
module opmode_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [6:0]       prog_opmode,
  input  logic [CNT_W-1:0] prog_rpt,
  input  logic             prog_last,
  input  logic             start,
  input  logic             abort,
  input  logic             dsp_ready,
  output logic [1:0]       x_sel,
  output logic [1:0]       y_sel,
  output logic [2:0]       z_sel,
  output logic             sel_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    cur_addr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Program memory, split by field.
  logic [6:0]       mem_op   [DEPTH];
  logic [CNT_W-1:0] mem_rpt  [DEPTH];
  logic [DEPTH-1:0] mem_last;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [AW-1:0]    addr_next;
  logic [6:0]       sel, sel_next;  // {z, y, x}
  logic             err_next;

  logic [6:0]       rd_op;
  logic [CNT_W-1:0] rd_rpt;
  logic             rd_last;
  logic             rd_illegal;

  // Memory cannot change while busy, so reading the current entry combinationally
  // is stable for the whole time it is being issued.
  assign rd_op   = mem_op[cur_addr];
  assign rd_rpt  = mem_rpt[cur_addr];
  assign rd_last = mem_last[cur_addr] || (cur_addr == AW'(DEPTH - 1));

  // Z input 6/7 does not exist; the M product must drive X and Y together.
  assign rd_illegal = (rd_op[6:4] >= 3'd6) ||
                      ((rd_op[1:0] == 2'b01) ^ (rd_op[3:2] == 2'b01));

  assign {z_sel, y_sel, x_sel} = sel;
  assign sel_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Program memory: cleared by reset, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_op[i]  <= '0;
        mem_rpt[i] <= '0;
      end
      mem_last <= '0;
    end else if (prog_we && (state == IDLE)) begin
      mem_op[prog_addr]   <= prog_opmode;
      mem_rpt[prog_addr]  <= prog_rpt;
      mem_last[prog_addr] <= prog_last;
    end
  end

  // Sequencer next-state: abort has priority over everything else.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = cur_addr;
    sel_next   = sel;
    err_next   = err;
    if (abort) begin
      state_next = IDLE;
      sel_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = LOAD;
            addr_next  = '0;
            err_next   = 1'b0;
          end
        end
        LOAD: begin
          cnt_next = rd_rpt;
          if (rd_illegal) begin
            state_next = IDLE;
            sel_next   = '0;
            err_next   = 1'b1;
          end else begin
            state_next = ISSUE;
            sel_next   = rd_op;
          end
        end
        ISSUE: begin
          if (dsp_ready) begin
            if (cnt != '0) begin
              cnt_next = cnt - CNT_W'(1);
            end else if (!rd_last) begin
              addr_next  = cur_addr + AW'(1);
              state_next = LOAD;
            end else begin
`ifdef OPSEQ_LOOP_EN
              addr_next  = '0;
              state_next = LOAD;
`else
              state_next = DONE;
`endif
            end
          end
        end
        DONE: begin
          state_next = IDLE;
          sel_next   = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      sel      <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      cur_addr <= addr_next;
      sel      <= sel_next;
      err      <= err_next;
    end
  end

endmodule

// File: tb/tb_opmode_sequencer.sv
// tb_opmode_sequencer: table-driven bench for opmode_sequencer plus hand-written
// sequences for async reset, the always-last final entry and the loop build.
`timescale 1ns/1ps
module tb_opmode_sequencer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int AW    = 3;

  localparam logic [6:0] E0   = 7'b011_01_01;
  localparam logic [6:0] E1   = 7'b010_00_11;
  localparam logic [6:0] BADZ = 7'b110_00_00;
  localparam logic [6:0] BADY = 7'b000_01_00;
  localparam logic [6:0] BADX = 7'b000_00_01;
  localparam logic [6:0] Z5   = 7'b101_00_00;

  logic             clk = 1'b0;
  logic             rst;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [6:0]       prog_opmode;
  logic [CNT_W-1:0] prog_rpt;
  logic             prog_last;
  logic             start;
  logic             abort;
  logic             dsp_ready;
  logic [1:0]       x_sel;
  logic [1:0]       y_sel;
  logic [2:0]       z_sel;
  logic             sel_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic [AW-1:0]    cur_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  opmode_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_opmode(prog_opmode),
    .prog_rpt(prog_rpt), .prog_last(prog_last),
    .start(start), .abort(abort), .dsp_ready(dsp_ready),
    .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel),
    .sel_valid(sel_valid), .busy(busy), .done(done), .err(err), .cur_addr(cur_addr)
  );

  // One clock of inputs and the outputs expected right after that edge.
  typedef struct {
    string      name;
    logic       we;
    logic [2:0] pa;
    logic [6:0] po;
    logic [7:0] pr;
    logic       pl;
    logic       st, ab, rdy;
    logic       cs;   // check selects
    logic [6:0] sel;  // {z, y, x}
    logic       ca;   // check cur_addr
    logic [2:0] a;
    logic       v, b, d, e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vrow(input string name, input logic we, input logic [2:0] pa,
                                input logic [6:0] po, input logic [7:0] pr, input logic pl,
                                input logic st, ab, rdy, cs, input logic [6:0] sel,
                                input logic ca, input logic [2:0] a, input logic v, b, d, e);
    vec_t t;
    t.name = name; t.we = we; t.pa = pa; t.po = po; t.pr = pr; t.pl = pl;
    t.st = st; t.ab = ab; t.rdy = rdy; t.cs = cs; t.sel = sel; t.ca = ca; t.a = a;
    t.v = v; t.b = b; t.d = d; t.e = e;
    return t;
  endfunction

  // Program write while idle: outputs stay at idle values.
  function automatic vec_t vprog(input string name, input logic [2:0] pa, input logic [6:0] po,
                                 input logic [7:0] pr, input logic pl, input logic e);
    return vrow(name, 1'b1, pa, po, pr, pl, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 3'd0,
                1'b0, 1'b0, 1'b0, e);
  endfunction

  function automatic vec_t vcyc(input string name, input logic st, ab, rdy, cs,
                                input logic [6:0] sel, input logic ca, input logic [2:0] a,
                                input logic v, b, d, e);
    return vrow(name, 1'b0, 3'd0, 7'd0, 8'd0, 1'b0, st, ab, rdy, cs, sel, ca, a, v, b, d, e);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [13:0] got, exp, mask;
    prog_we = t.we; prog_addr = t.pa; prog_opmode = t.po; prog_rpt = t.pr; prog_last = t.pl;
    start = t.st; abort = t.ab; dsp_ready = t.rdy;
    step();
    got  = {z_sel, y_sel, x_sel, cur_addr, sel_valid, busy, done, err};
    exp  = {t.sel, t.a, t.v, t.b, t.d, t.e};
    mask = {{7{t.cs}}, {3{t.ca}}, 4'hF};
    tests++;
    if ((got & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL row %0d %s: got %h expected %h (mask %h)", idx, t.name, got, exp, mask);
    end
    prog_we = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic prog_write(input logic [2:0] a, input logic [6:0] op, input logic [7:0] r,
                            input logic l);
    prog_we = 1'b1; prog_addr = a; prog_opmode = op; prog_rpt = r; prog_last = l;
    step();
    prog_we = 1'b0;
  endtask

  task automatic build_table();
    // Two-entry run: 3 beats of E0, bubble, 1 beat of E1, done.
    vecs.push_back(vprog("A prog0", 3'd0, E0, 8'd2, 1'b0, 1'b0));
    vecs.push_back(vprog("A prog1", 3'd1, E1, 8'd0, 1'b1, 1'b0));
    vecs.push_back(vcyc("A load0",  1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(vcyc("A issue0", 0, 0, 1, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("A bubble", 0, 0, 1, 0, 7'd0, 1, 3'd1, 0, 1, 0, 0));
    vecs.push_back(vcyc("A issue1", 0, 0, 1, 1, E1, 1, 3'd1, 1, 1, 0, 0));
    vecs.push_back(vcyc("A done",   0, 0, 1, 0, 7'd0, 1, 3'd1, 0, 1, 1, 0));
    vecs.push_back(vcyc("A idle",   0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    // Backpressure on second beat for three cycles.
    vecs.push_back(vcyc("B load0",  1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vcyc("B beat1",  0, 0, 1, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("B beat2",  0, 0, 1, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(vcyc("B stall", 0, 0, 0, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("B beat3",  0, 0, 1, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("B bubble", 0, 0, 1, 0, 7'd0, 1, 3'd1, 0, 1, 0, 0));
    vecs.push_back(vcyc("B issue1", 0, 0, 1, 1, E1, 1, 3'd1, 1, 1, 0, 0));
    vecs.push_back(vcyc("B done",   0, 0, 1, 0, 7'd0, 1, 3'd1, 0, 1, 1, 0));
    vecs.push_back(vcyc("B idle",   0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    // Abort while entry 1 is presented with ready high.
    vecs.push_back(vcyc("C load0",  1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(vcyc("C issue0", 0, 0, 1, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("C bubble", 0, 0, 1, 0, 7'd0, 1, 3'd1, 0, 1, 0, 0));
    vecs.push_back(vcyc("C issue1", 0, 0, 1, 1, E1, 1, 3'd1, 1, 1, 0, 0));
    vecs.push_back(vcyc("C abort",  0, 1, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(vcyc("C nodone", 0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    // start together with abort in idle.
    vecs.push_back(vcyc("D collide", 1, 1, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(vcyc("D stays",   0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    // Illegal Z = 6.
    vecs.push_back(vprog("E prog", 3'd0, BADZ, 8'd0, 1'b1, 1'b0));
    vecs.push_back(vcyc("E load",   1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vcyc("E err",    0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 1));
    vecs.push_back(vcyc("E sticky", 0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 1));
    // Illegal: Y=M without X=M; err cleared by start, set again; abort keeps it.
    vecs.push_back(vprog("F prog", 3'd0, BADY, 8'd0, 1'b1, 1'b1));
    vecs.push_back(vcyc("F load",   1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vcyc("F err",    0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 1));
    vecs.push_back(vcyc("F keep",   1, 1, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 1));
    // Illegal: X=M without Y=M.
    vecs.push_back(vprog("I prog", 3'd0, BADX, 8'd0, 1'b1, 1'b1));
    vecs.push_back(vcyc("I load",   1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vcyc("I err",    0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 1));
    // Z = 5 is the highest legal select.
    vecs.push_back(vprog("H prog", 3'd0, Z5, 8'd0, 1'b1, 1'b1));
    vecs.push_back(vcyc("H load",   1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vcyc("H issue",  0, 0, 1, 1, Z5, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("H done",   0, 0, 1, 0, 7'd0, 0, 3'd0, 0, 1, 1, 0));
    vecs.push_back(vcyc("H idle",   0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
    // Writes while busy are dropped.
    vecs.push_back(vprog("W prog", 3'd0, E0, 8'd0, 1'b1, 1'b0));
    vecs.push_back(vcyc("W load",   1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vrow("W we@load",  1, 3'd0, BADZ, 8'd0, 1, 0, 0, 1, 1, E0, 1, 3'd0,
                        1, 1, 0, 0));
    vecs.push_back(vrow("W we@issue", 1, 3'd0, BADZ, 8'd0, 1, 0, 0, 1, 0, 7'd0, 0, 3'd0,
                        0, 1, 1, 0));
    vecs.push_back(vrow("W we@done",  1, 3'd0, BADZ, 8'd0, 1, 0, 0, 1, 1, 7'd0, 0, 3'd0,
                        0, 0, 0, 0));
    vecs.push_back(vcyc("W reload", 1, 0, 1, 0, 7'd0, 1, 3'd0, 0, 1, 0, 0));
    vecs.push_back(vcyc("W issue",  0, 0, 1, 1, E0, 1, 3'd0, 1, 1, 0, 0));
    vecs.push_back(vcyc("W done",   0, 0, 1, 0, 7'd0, 0, 3'd0, 0, 1, 1, 0));
    vecs.push_back(vcyc("W idle",   0, 0, 1, 1, 7'd0, 0, 3'd0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_opmode = '0; prog_rpt = '0; prog_last = 1'b0;
    start = 1'b0; abort = 1'b0; dsp_ready = 1'b1;
    @(negedge clk);
    check("reset outputs", {25'd0, z_sel, y_sel, x_sel, sel_valid, busy, done, err, cur_addr},
          32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef OPSEQ_LOOP_EN
    // One-entry program, R=1: pattern LOAD, ISSUE, ISSUE repeating, never done.
    prog_write(3'd0, E0, 8'd1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("loop first load", {30'd0, sel_valid, busy}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check("loop valid", {29'd0, sel_valid, busy, done}, {29'd0, (k % 3) != 0, 1'b1, 1'b0});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("loop abort", {29'd0, sel_valid, busy, done}, 32'd0);
    step();
    check("loop stays idle", {29'd0, sel_valid, busy, done}, 32'd0);
`else
    build_table();
    foreach (vecs[i]) apply(vecs[i], i);

    // Async reset in the middle of ISSUE.
    prog_write(3'd0, E0, 8'd5, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre-reset issue", {25'd0, z_sel, y_sel, x_sel, sel_valid}, {25'd0, E0, 1'b1});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset", {25'd0, z_sel, y_sel, x_sel, sel_valid, busy, done, err, cur_addr},
          32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cleared memory: eight zero entries, entry 7 treated as last.
    begin
      int nvalid = 0;
      int badsel = 0;
      int seen   = 0;
      logic [2:0] done_addr = '0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
        if (sel_valid) begin
          nvalid++;
          if ({z_sel, y_sel, x_sel} != 7'd0) badsel++;
        end
        if (done) begin
          seen = 1;
          done_addr = cur_addr;
        end else begin
          step();
        end
      end
      check("post-reset done seen", seen, 1);
      check("post-reset beats", nvalid, 8);
      check("post-reset selects zero", badsel, 0);
      check("post-reset last addr", {29'd0, done_addr}, 32'd7);
      step();
      check("post-reset idle", {30'd0, busy, done}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/opmode_sequencer.md
# opmode_sequencer

Programmable micro-sequencer that drives the X/Y/Z operand-select fields (OPMODE[1:0], [3:2], [6:4]) of the DSP48E1 datapath. A small program memory holds OPMODE words with per-entry repeat counts. On `start` it issues them in order to the X, Y and Z muxes under a valid/ready handshake. Illegal select combinations are rejected before they reach the datapath.

## Interface
- `DEPTH`, 8, number of program entries (power of 2, ≥2); `AW = $clog2(DEPTH)`
- `CNT_W`, 8, width of per-entry repeat count
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `prog_we`  in  1  program write strobe
- `prog_addr`  in  AW  entry to write
- `prog_opmode`  in  7  {z_sel[2:0], y_sel[1:0], x_sel[1:0]}
- `prog_rpt`  in  CNT_W  repeat count R; entry issues R+1 beats
- `prog_last`  in  1  marks entry as end of program
- `start`  in  1  begin sequence at entry 0
- `abort`  in  1  terminate sequence immediately
- `dsp_ready`  in  1  datapath accepts current selects
- `x_sel`  out  2  X mux select (OPMODE[1:0])
- `y_sel`  out  2  Y mux select (OPMODE[3:2])
- `z_sel`  out  3  Z mux select (OPMODE[6:4])
- `sel_valid`  out  1  selects valid this cycle
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse, normal completion
- `err`  out  1  sticky illegal-OPMODE flag
- `cur_addr`  out  AW  entry currently loaded/issued

## Operation
- Memory: DEPTH × (7 + CNT_W + 1) registers. Reset clears all to 0. Writes are accepted only when `busy`=0; they are ignored while busy. Entry DEPTH-1 is always treated as last.
- FSM states: IDLE, LOAD, ISSUE, DONE.
- IDLE: `busy`=0 and `sel_valid`=0. Selects are 0. `start`=1 (and `abort`=0) → LOAD, `cur_addr`←0, `err`←0.
- LOAD: read entry `cur_addr` into the sel registers, `cnt`←R, then run the legality check.
  - Illegal → IDLE, `err`←1, no `done`.
  - Legal → ISSUE.
- Illegal when any of these holds: `z_sel` ≥ 6 (only Z inputs 0–5 exist); (`x_sel`==01) XOR (`y_sel`==01), meaning the M product must feed X and Y together. All other codes are legal.
- ISSUE: `sel_valid`=1, selects held stable. A beat completes on `sel_valid && dsp_ready`.
  - Beat with `cnt`≠0: `cnt`−1, stay in ISSUE.
  - Beat with `cnt`==0 on a non-last entry: `cur_addr`+1 → LOAD.
  - Beat with `cnt`==0 on the last entry: → DONE.
- DONE: `done`=1, `sel_valid`=0 → IDLE.
- `abort`=1 in any state → IDLE next cycle. `sel_valid` and `busy` drop, no `done`, `err` unchanged. `abort` wins over a simultaneous `start`.
- `start` while busy is ignored.
- `busy`=1 in LOAD, ISSUE and DONE.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt`=0, memory 0.
- `start` sampled at edge N: LOAD during cycle N+1, first `sel_valid`=1 in cycle N+2.
- Entry boundary costs one bubble cycle (LOAD, `sel_valid`=0).
- An entry with R and `dsp_ready` held high occupies exactly R+1 ISSUE cycles.
- `done` is asserted the cycle after the final accepted beat, for exactly one cycle.
- Selects must not change while `sel_valid`=1 && `dsp_ready`=0.
- `rst` asserted mid-sequence forces reset values asynchronously. The program memory is also cleared.
- `err` stays set until the next accepted `start`.

## Configuration
- `OPSEQ_LOOP_EN` defined: after the last entry's final beat, go to LOAD with `cur_addr`←0 instead of DONE. The sequence repeats until `abort`. `done` never pulses.
- Undefined: single pass ending in DONE as above. No wrap logic is synthesized.

## Test plan
- Reset: assert `rst` mid-ISSUE → all outputs 0 immediately; after release, reading entry 0 via `start` yields selects 0.
- Two-entry program: entry0 opmode 7'b011_01_01, R=2; entry1 opmode 7'b010_00_11, R=0, last; `dsp_ready`=1.
  - `start`@N → `sel_valid` in cycles N+2..N+4 with x=01/y=01/z=011.
  - Bubble at N+5.
  - x=11/y=00/z=010 at N+6.
  - `done` at N+7.
- Backpressure: same program, `dsp_ready` low for 3 cycles on the second beat → selects held constant, total ISSUE cycles = 4+3, `cnt` not decremented while stalled.
- Illegal entries:
  - opmode 7'b110_00_00 → after LOAD, `err`=1, `sel_valid` never rises, no `done`.
  - opmode 7'b000_01_00 → `err`=1.
- Abort/start collision: `abort` during ISSUE of entry 1 → IDLE next cycle, no `done`. `start` and `abort` together in IDLE → remains IDLE. `prog_we` while busy → memory unchanged.
- `OPSEQ_LOOP_EN` build: one-entry last program with R=1 → beats repeat as 2 valid + 1 bubble, indefinitely for 20 cycles, `done`=0; `abort` stops the loop.
